telemetry_framer: RTL and testbench

- Downstream formatter for the CPLD sensor top level. Takes the decoded encoder, ADC, temperature and bill-acceptor values and emits one ASCII hex telemetry line per frame.
- Drives the async_transmitter (TxD_start / TxD_data / TxD_busy handshake).
- Replaces the top level's inline per-byte case table and adds change detection, field snapshotting and a heartbeat.
- Runs on the 10 MHz board clock.

---
 rtl/telemetry_pkg.sv | 47 ++++
 rtl/telemetry_byte_mux.sv | 41 ++++
 rtl/telemetry_framer.sv | 149 ++++++++++++++
 tb/tb_telemetry_framer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : telemetry_pkg
// Purpose  : Shared frame layout, ASCII constants, FSM encoding and hex helper.
// Revision : 1.0
// ============================================================================
package telemetry_pkg;

    localparam int FRAME_LEN = 18;
    localparam int IDX_W     = 5;

    // First byte of each field within the 18-byte line
    localparam logic [IDX_W-1:0] IDX_E1   = 5'd0;
    localparam logic [IDX_W-1:0] IDX_E2   = 5'd4;
    localparam logic [IDX_W-1:0] IDX_ADC  = 5'd8;
    localparam logic [IDX_W-1:0] IDX_TEMP = 5'd11;
    localparam logic [IDX_W-1:0] IDX_BILL = 5'd14;
    localparam logic [IDX_W-1:0] IDX_CR   = 5'd16;
    localparam logic [IDX_W-1:0] IDX_LF   = 5'd17;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    localparam logic [7:0] SP = 8'h20;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_GUARD = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    typedef struct packed {
        logic [11:0] enc1;
        logic [11:0] enc2;
        logic [7:0]  adc;
        logic [7:0]  temp;
        logic [7:0]  bill;
    } snap_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? ({4'h0, nib} + 8'h30) : ({4'h0, nib} + 8'h37);
    endfunction

endpackage
`default_nettype wire

// File: rtl/telemetry_byte_mux.sv
`default_nettype none
// ============================================================================
// Module   : telemetry_byte_mux
// Purpose  : Combinational map from byte index and field snapshot to line byte.
// Revision : 1.0
// ============================================================================
module telemetry_byte_mux
    import telemetry_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  snap_t            snap,
    output logic [7:0]       byte_out
);

    always_comb begin
        byte_out = 8'h00;
        case (idx)
            IDX_E1:            byte_out = hex_ascii(snap.enc1[11:8]);
            IDX_E1 + 5'd1:     byte_out = hex_ascii(snap.enc1[7:4]);
            IDX_E1 + 5'd2:     byte_out = hex_ascii(snap.enc1[3:0]);
            IDX_E1 + 5'd3:     byte_out = SP;
            IDX_E2:            byte_out = hex_ascii(snap.enc2[11:8]);
            IDX_E2 + 5'd1:     byte_out = hex_ascii(snap.enc2[7:4]);
            IDX_E2 + 5'd2:     byte_out = hex_ascii(snap.enc2[3:0]);
            IDX_E2 + 5'd3:     byte_out = SP;
            IDX_ADC:           byte_out = hex_ascii(snap.adc[7:4]);
            IDX_ADC + 5'd1:    byte_out = hex_ascii(snap.adc[3:0]);
            IDX_ADC + 5'd2:    byte_out = SP;
            IDX_TEMP:          byte_out = hex_ascii(snap.temp[7:4]);
            IDX_TEMP + 5'd1:   byte_out = hex_ascii(snap.temp[3:0]);
            IDX_TEMP + 5'd2:   byte_out = SP;
            IDX_BILL:          byte_out = hex_ascii(snap.bill[7:4]);
            IDX_BILL + 5'd1:   byte_out = hex_ascii(snap.bill[3:0]);
            IDX_CR:            byte_out = CR;
            IDX_LF:            byte_out = LF;
            default:           byte_out = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/telemetry_framer.sv
`default_nettype none
// ============================================================================
// Module   : telemetry_framer
// Purpose  : Snapshots sensor fields and streams one ASCII hex line per frame.
// Revision : 1.0
// ============================================================================
module telemetry_framer
    import telemetry_pkg::*;
#(
    parameter int HEARTBEAT_TICKS = 256,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send_tick,
    input  logic [11:0]      enc1_pos,
    input  logic [11:0]      enc2_pos,
    input  logic [7:0]       adc_data,
    input  logic [7:0]       temperature,
    input  logic [7:0]       bill_acc,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             frame_busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count
);

    localparam int HB_W = (HEARTBEAT_TICKS > 1) ? $clog2(HEARTBEAT_TICKS) : 1;
    localparam logic [HB_W-1:0] HB_MAX =
        (HEARTBEAT_TICKS > 0) ? HB_W'(HEARTBEAT_TICKS - 1) : '0;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    snap_t             snap_q, snap_d;
    snap_t             last_q, last_d;
    logic              first_q, first_d;
    logic [HB_W-1:0]   hb_q, hb_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              frame_busy_q, frame_busy_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  frame_count_q, frame_count_d;

    snap_t             snap_in;
    logic              send_now;
    logic [7:0]        mux_byte;

    telemetry_byte_mux u_byte_mux (
        .idx      (idx_q),
        .snap     (snap_q),
        .byte_out (mux_byte)
    );

    always_comb begin
        snap_in  = {enc1_pos, enc2_pos, adc_data, temperature, bill_acc};
        send_now = first_q || (snap_in != last_q) ||
                   ((HEARTBEAT_TICKS != 0) && (hb_q == HB_MAX));

        state_d       = state_q;
        idx_d         = idx_q;
        snap_d        = snap_q;
        last_d        = last_q;
        first_d       = first_q;
        hb_d          = hb_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        frame_busy_d  = frame_busy_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;

        case (state_q)
            ST_IDLE: begin
                if (send_tick) begin
                    if (send_now) begin
                        state_d      = ST_LOAD;
                        frame_busy_d = 1'b1;
                        idx_d        = '0;
                        snap_d       = snap_in;
                        last_d       = snap_in;
                        first_d      = 1'b0;
                        hb_d         = '0;
                    end else if (hb_q != HB_MAX) begin
                        hb_d = hb_q + HB_W'(1);
                    end
                end
            end
            ST_LOAD: begin
                // tx_start rises together with the new byte so START sees both
                tx_data_d  = mux_byte;
                tx_start_d = 1'b1;
                state_d    = ST_START;
            end
            ST_START: state_d = ST_GUARD;
            // transmitter raises busy one cycle after start; don't sample it yet
            ST_GUARD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!tx_busy) begin
                    if (idx_q == IDX_LAST) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + CNT_W'(1);
                        frame_busy_d  = 1'b0;
                        state_d       = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            snap_q        <= '0;
            last_q        <= '0;
            first_q       <= 1'b1;
            hb_q          <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            frame_busy_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            last_q        <= last_d;
            first_q       <= first_d;
            hb_q          <= hb_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            frame_busy_q  <= frame_busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign frame_busy  = frame_busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_telemetry_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_telemetry_framer
// Purpose  : Directed self-checking bench for telemetry_framer.
// Revision : 1.0
// ============================================================================
module tb_telemetry_framer;

    localparam int HB = 4;
    localparam int CW = 3;
    localparam int FL = 18;
    typedef logic [7:0] line_t [FL];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          send_tick = 1'b0;
    logic [11:0]   enc1_pos = '0;
    logic [11:0]   enc2_pos = '0;
    logic [7:0]    adc_data = '0;
    logic [7:0]    temperature = '0;
    logic [7:0]    bill_acc = '0;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          frame_busy;
    logic          frame_done;
    logic [CW-1:0] frame_count;

    int n_cmp  = 0;
    int n_fail = 0;

    telemetry_framer #(.HEARTBEAT_TICKS(HB), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .send_tick   (send_tick),
        .enc1_pos    (enc1_pos),
        .enc2_pos    (enc2_pos),
        .adc_data    (adc_data),
        .temperature (temperature),
        .bill_acc    (bill_acc),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #50 clk = ~clk;

    // Transmitter stand-in: busy for busy_len cycles starting the cycle after start
    int busy_len = 10;
    int busy_cnt = 0;
    assign tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (rst)                busy_cnt <= 0;
        else if (tx_start)      busy_cnt <= busy_len;
        else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
    end

    // Behavioural model: frame decisions from the trigger rules, line text via formatting
    logic [47:0] cur;
    assign cur = {enc1_pos, enc2_pos, adc_data, temperature, bill_acc};

    logic        m_busy;
    logic        m_first;
    int          m_hb;
    logic [47:0] m_last;
    int          m_count;
    line_t       m_line;

    function automatic line_t make_line(input logic [47:0] s);
        line_t l;
        string t;
        t = $sformatf("%h %h %h %h %h", s[47:36], s[35:24], s[23:16], s[15:8], s[7:0]);
        t = t.toupper();
        for (int i = 0; i < 16; i++) l[i] = t[i];
        l[16] = 8'h0D;
        l[17] = 8'h0A;
        return l;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_first <= 1'b1;
            m_hb    <= 0;
            m_last  <= '0;
            m_count <= 0;
        end else begin
            if (frame_done) begin
                m_busy  <= 1'b0;
                m_count <= m_count + 1;
            end
            if (send_tick && (!m_busy || frame_done)) begin
                if (m_first || cur != m_last || (HB > 0 && m_hb >= HB - 1)) begin
                    m_busy  <= 1'b1;
                    m_first <= 1'b0;
                    m_hb    <= 0;
                    m_last  <= cur;
                    m_line  <= make_line(cur);
                end else begin
                    m_hb <= (m_hb + 1 > HB - 1) ? HB - 1 : m_hb + 1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    int    cap_idx = 0;
    line_t cap_line;
    line_t last_line;

    task automatic run_checker();
        forever begin
            @(negedge clk);
            if (rst) begin
                cap_idx = 0;
            end else begin
                if (tx_start) begin
                    check("start_while_busy", 32'(tx_busy), 32'd0);
                    if (cap_idx < FL) begin
                        check($sformatf("byte%0d", cap_idx), 32'(tx_data), 32'(m_line[cap_idx]));
                        cap_line[cap_idx] = tx_data;
                    end else begin
                        check("byte_overrun", cap_idx, FL - 1);
                    end
                    cap_idx++;
                end
                if (frame_done) begin
                    check("frame_len", cap_idx, FL);
                    last_line = cap_line;
                    cap_idx   = 0;
                end
            end
            check("frame_busy", 32'(frame_busy), 32'(m_busy && !frame_done));
            check("frame_count", 32'(frame_count), 32'((m_count + int'(frame_done)) % (1 << CW)));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        send_tick = 1'b1;
        @(negedge clk);
        send_tick = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            seen = frame_done;
        end
        check("frame_done_seen", 32'(seen), 32'd1);
        #1;
    endtask

    task automatic wait_bytes(input int n);
        for (int k = 0; k < 3000 && cap_idx < n; k++) @(negedge clk);
        check("bytes_seen", 32'(cap_idx >= n), 32'd1);
    endtask

    task automatic check_line(input string nm, input string s);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s[%0d]", nm, i), 32'(last_line[i]), 32'(s[i]));
        check({nm, "[cr]"}, 32'(last_line[16]), 32'h0D);
        check({nm, "[lf]"}, 32'(last_line[17]), 32'h0A);
    endtask

    task automatic stimulus();
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_frame_busy", 32'(frame_busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        #20 rst = 1'b0;

        enc1_pos = 12'hABC; enc2_pos = 12'h012;
        adc_data = 8'h7F; temperature = 8'h19; bill_acc = 8'h05;
        tick();
        wait_done();
        check_line("first", "ABC 012 7F 19 05");
        check("count_first", 32'(frame_count), 1);

        // Unchanged inputs: only every 4th tick forces a frame
        for (int i = 1; i <= 10; i++) begin
            tick();
            repeat (3) @(negedge clk);
            if (i == 4 || i == 8) begin
                check($sformatf("hb_tick%0d_busy", i), 32'(frame_busy), 1);
                wait_done();
                check_line("hb", "ABC 012 7F 19 05");
            end else begin
                check($sformatf("hb_tick%0d_idle", i), 32'(frame_busy), 0);
            end
        end
        check("count_hb", 32'(frame_count), 3);

        // Heartbeat counter is at 2: one idle tick, then a forced frame torn by nothing
        tick();
        repeat (3) @(negedge clk);
        check("hb_tick11_idle", 32'(frame_busy), 0);
        tick();
        wait_bytes(3);
        enc1_pos = 12'hFFF;
        tick();
        wait_done();
        check_line("no_tear", "ABC 012 7F 19 05");
        repeat (6) @(negedge clk);
        check("tick_not_queued", 32'(frame_busy), 0);
        tick();
        wait_done();
        check_line("changed", "FFF 012 7F 19 05");
        check("count_changed", 32'(frame_count), 5);

        // Reset in the middle of a frame, then a full resend
        enc1_pos = 12'h9A0; adc_data = 8'hF0;
        tick();
        wait_bytes(9);
        @(negedge clk);
        #20 rst = 1'b1;
        #1;
        check("midrst_tx_start", 32'(tx_start), 0);
        check("midrst_frame_busy", 32'(frame_busy), 0);
        check("midrst_frame_count", 32'(frame_count), 0);
        check("midrst_tx_data", 32'(tx_data), 0);
        repeat (2) @(negedge clk);
        #20 rst = 1'b0;
        tick();
        wait_done();
        check_line("after_rst", "9A0 012 F0 19 05");
        check("count_after_rst", 32'(frame_count), 1);

        // Counter wrap with an idle transmitter
        busy_len = 0;
        for (int i = 0; i < 7; i++) begin
            bill_acc = 8'h10 + 8'(i);
            tick();
            wait_done();
        end
        check_line("wrap_last", "9A0 012 F0 19 16");
        check("count_wrap", 32'(frame_count), 0);
    endtask

    initial begin
        fork
            run_checker();
            stimulus();
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
